// File: rtl/uart_reg_access_arbiter_pkg.sv
// rtl/uart_reg_access_arbiter_pkg.sv - shared constants and FSM states for the UART register access arbiter
package uart_reg_access_arbiter_pkg;

    localparam logic [1:0] REG_STAT = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_TX   = 2'd2;
    localparam logic [1:0] REG_RX   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin winner select, search starts after last_gnt_i
module uart_rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_gnt_i,
    output logic [N_REQ-1:0] win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             win_valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        win_oh_o    = '0;
        win_idx_o   = '0;
        win_valid_o = 1'b0;
        idx         = last_gnt_i;
        for (int i = 0; i < N_REQ; i++) begin
            // step with explicit wrap so non-power-of-two N_REQ stays in range
            idx = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
            if (!win_valid_o && req_i[idx]) begin
                win_valid_o   = 1'b1;
                win_oh_o[idx] = 1'b1;
                win_idx_o     = idx;
            end
        end
    end

endmodule

// File: rtl/uart_reg_access_arbiter.sv
// rtl/uart_reg_access_arbiter.sv - round-robin sharing of the UART register port, one strobe per grant
module uart_reg_access_arbiter
    import uart_reg_access_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [N_REQ-1:0]            req_i,
    input  logic [N_REQ-1:0]            we_i,
    input  logic [N_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [N_REQ-1:0]            gnt_o,
    output logic [N_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic                        busy_o,
    output logic [ADDR_WIDTH-1:0]       reg_addr_o,
    output logic [DATA_WIDTH-1:0]       reg_wdata_o,
    output logic                        reg_wr_en_o,
    output logic                        reg_rd_en_o,
    input  logic [DATA_WIDTH-1:0]       reg_rdata_i
);

    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        last_gnt_q, last_gnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d;
    logic [N_REQ-1:0]        rvalid_q, rvalid_d;
    logic                    busy_q, busy_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;

    logic [N_REQ-1:0]        win_oh;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_valid;

    uart_rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i       (req_i),
        .last_gnt_i  (last_gnt_q),
        .win_oh_o    (win_oh),
        .win_idx_o   (win_idx),
        .win_valid_o (win_valid)
    );

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        we_d        = we_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        rdata_d     = rdata_q;
        gnt_d       = '0;
        rvalid_d    = '0;
        busy_d      = 1'b0;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    state_d     = ST_ACCESS;
                    last_gnt_d  = win_idx;
                    we_d        = we_i[win_idx];
                    reg_addr_d  = addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                    reg_wdata_d = wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    gnt_d       = win_oh;
                    wr_en_d     = we_i[win_idx];
                    rd_en_d     = !we_i[win_idx];
                    busy_d      = 1'b1;
                end
            end
            ST_ACCESS: begin
                // read data sampled on the strobe edge, before any read-clear takes effect
                state_d  = ST_RESP;
                rvalid_d = gnt_q;
                rdata_d  = we_q ? '0 : reg_rdata_i;
                busy_d   = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= IDX_W'(N_REQ - 1);
            we_q        <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            rdata_q     <= '0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            busy_q      <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            we_q        <= we_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            rdata_q     <= rdata_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign busy_o      = busy_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_wdata_o = reg_wdata_q;
    assign reg_wr_en_o = wr_en_q;
    assign reg_rd_en_o = rd_en_q;

endmodule

// File: tb/tb_uart_reg_access_arbiter.sv
// tb/tb_uart_reg_access_arbiter.sv - directed and random checks of the register access arbiter
module tb_uart_reg_access_arbiter;
    import uart_reg_access_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int AW = 2;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, reg_wdata, reg_rdata;
    logic            busy, reg_wr_en, reg_rd_en;
    logic [AW-1:0]   reg_addr;

    logic [DW-1:0]   rf [4];
    assign reg_rdata = rf[reg_addr];

    uart_reg_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(N)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .busy_o(busy),
        .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_wr_en_o(reg_wr_en),
        .reg_rd_en_o(reg_rd_en), .reg_rdata_i(reg_rdata)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;

    // requesters
    logic [N-1:0]  pend, drop, keep;
    logic [N-1:0]  pwe;
    logic [AW-1:0] paddr [N];
    logic [DW-1:0] pwdata [N];
    bit            rand_mode = 0;

    // reference model: timeline of the single transaction in flight
    int            m_free, m_last, acc_c, resp_c, m_w;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [DW-1:0] mregs [4];
    logic          mp_wr, mp_clr, ep_wr, ep_clr;
    logic [AW-1:0] mp_addr, ep_addr;
    logic [DW-1:0] mp_data, ep_data;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic pack();
        for (int k = 0; k < N; k++) begin
            req[k] = pend[k];
            we[k]  = pwe[k];
            addr[k*AW +: AW]  = paddr[k];
            wdata[k*DW +: DW] = pwdata[k];
        end
    endtask

    task automatic set_txn(int k, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
        pend[k] = 1'b1; pwe[k] = w; paddr[k] = a; pwdata[k] = d;
        pack();
    endtask

    task automatic model_reset();
        m_free = cyc + 1; m_last = N - 1; acc_c = -100; resp_c = -100; m_w = 0;
        m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        mp_wr = 0; mp_clr = 0; ep_wr = 0; ep_clr = 0; drop = '0;
    endtask

    task automatic step();
        logic [DW-1:0] ev;
        bit found;
        int kk;
        @(posedge clk); #1; cyc++;
        if (ep_wr) rf[ep_addr] = ep_data;
        if (ep_clr) rf[REG_STAT] = '0;
        if (mp_wr) mregs[mp_addr] = mp_data;
        if (mp_clr) mregs[REG_STAT] = '0;
        ep_wr = 0; ep_clr = 0; mp_wr = 0; mp_clr = 0;
        // arbitration decision for the request vector sampled at this edge
        found = 0;
        if (cyc >= m_free && req != '0) begin
            for (int i = 1; i <= N; i++) begin
                kk = (m_last + i) % N;
                if (!found && req[kk]) begin found = 1; m_w = kk; end
            end
            m_last = m_w; m_we = we[m_w];
            m_addr = addr[m_w*AW +: AW]; m_wdata = wdata[m_w*DW +: DW];
            acc_c = cyc; resp_c = cyc + 1; m_free = cyc + 3;
        end
        if (rand_mode && $urandom_range(0, 15) == 0) begin
            ev = $urandom & 32'h0001_0101;
            rf[REG_STAT] = rf[REG_STAT] | ev;
            mregs[REG_STAT] = mregs[REG_STAT] | ev;
        end
        if (found) begin
            m_rdata = m_we ? '0 : mregs[m_addr];
            if (m_we) begin mp_wr = 1; mp_addr = m_addr; mp_data = m_wdata; end
            else if (m_addr == REG_STAT) mp_clr = 1;
        end
        chk("gnt", gnt, (cyc == acc_c) ? (N'(1) << m_w) : '0);
        chk("wr_en", reg_wr_en, (cyc == acc_c) && m_we);
        chk("rd_en", reg_rd_en, (cyc == acc_c) && !m_we);
        chk("busy", busy, (cyc == acc_c) || (cyc == resp_c));
        chk("rvalid", rvalid, (cyc == resp_c) ? (N'(1) << m_w) : '0);
        chk("reg_addr", reg_addr, m_addr);
        chk("reg_wdata", reg_wdata, m_wdata);
        if (cyc == resp_c) chk("rdata", rdata, m_rdata);
        ep_wr = reg_wr_en; ep_addr = reg_addr; ep_data = reg_wdata;
        ep_clr = reg_rd_en && (reg_addr == REG_STAT);
        for (int k = 0; k < N; k++) begin
            if (drop[k]) begin
                drop[k] = 0;
                pend[k] = keep[k];
                if (keep[k] && rand_mode) begin
                    pwe[k] = 1'($urandom_range(0, 1)); paddr[k] = AW'($urandom_range(0, 3)); pwdata[k] = $urandom;
                end
            end
            if (gnt[k]) drop[k] = 1;
            if (rand_mode && !pend[k] && !drop[k] && $urandom_range(0, 3) == 0) begin
                pend[k] = 1; pwe[k] = 1'($urandom_range(0, 1));
                paddr[k] = AW'($urandom_range(0, 3)); pwdata[k] = $urandom;
            end
        end
        pack();
    endtask

    task automatic steps(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int gseq [8];
    int gcyc [8];
    int ng, idle_hits;

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; pend = '0; drop = '0; keep = '0; pwe = '0;
        for (int k = 0; k < N; k++) begin paddr[k] = '0; pwdata[k] = '0; end
        for (int r = 0; r < 4; r++) begin rf[r] = '0; mregs[r] = '0; end
        pack();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 0;
        chk("rst_gnt", gnt, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {reg_wr_en, reg_rd_en}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr", reg_addr, 0);
        model_reset();

        // single read
        rf[1] = 32'h55; mregs[1] = 32'h55;
        set_txn(0, 0, 2'd1, 32'h0);
        step();
        chk("rd_gnt_lit", gnt, 2'b01);
        chk("rd_en_lit", reg_rd_en, 1);
        step();
        chk("rd_rvalid_lit", rvalid, 2'b01);
        chk("rd_data_lit", rdata, 32'h55);
        steps(2);

        // single write
        set_txn(1, 1, 2'd2, 32'hA5);
        step();
        chk("wr_en_lit", reg_wr_en, 1);
        chk("wr_addr_lit", reg_addr, 2);
        chk("wr_data_lit", reg_wdata, 32'hA5);
        step();
        chk("wr_rvalid_lit", rvalid, 2'b10);
        chk("wr_rdata_lit", rdata, 0);
        steps(2);
        chk("wr_rf_lit", rf[2], 32'hA5);

        // contention: both hold requests continuously
        keep = 2'b11;
        set_txn(0, 0, 2'd3, 32'h0);
        set_txn(1, 0, 2'd3, 32'h0);
        ng = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (gnt != '0 && ng < 8) begin
                gseq[ng] = (gnt == 2'b10) ? 1 : 0; gcyc[ng] = cyc; ng++;
            end
        end
        chk("cont_count", ng, 4);
        for (int i = 0; i < 4; i++) chk("cont_order", gseq[i], i % 2);
        for (int i = 1; i < 4; i++) chk("cont_spacing", gcyc[i] - gcyc[i-1], 3);
        keep = '0;
        steps(10);

        // read-clear status register
        rf[REG_STAT] = 32'h10001; mregs[REG_STAT] = 32'h10001;
        set_txn(0, 0, REG_STAT, 32'h0);
        steps(2);
        chk("rc_first_lit", rdata, 32'h10001);
        steps(2);
        set_txn(0, 0, REG_STAT, 32'h0);
        steps(2);
        chk("rc_second_lit", rdata, 0);
        steps(2);

        // reset while the write strobe is active
        set_txn(1, 1, 2'd2, 32'h77);
        step();
        chk("rstacc_wr_before", reg_wr_en, 1);
        #2 rst = 1;
        #1;
        chk("rstacc_wr_async", reg_wr_en, 0);
        chk("rstacc_gnt_async", gnt, 0);
        chk("rstacc_busy_async", busy, 0);
        @(posedge clk); #1; cyc++;
        chk("rstacc_rvalid", rvalid, 0);
        #3 rst = 0;
        model_reset();
        chk("rstacc_no_write", rf[2], 32'hA5);
        set_txn(0, 0, 2'd1, 32'h0);
        set_txn(1, 0, 2'd1, 32'h0);
        step();
        chk("rstacc_req0_wins", gnt, 2'b01);
        steps(10);

        // idle stability
        pend = '0; pack();
        steps(3);
        idle_hits = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (busy || reg_wr_en || reg_rd_en || gnt != '0 || rvalid != '0) idle_hits++;
        end
        chk("idle_quiet", idle_hits, 0);

        // randomized traffic against the model
        rand_mode = 1;
        keep = '0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) keep = N'($urandom_range(0, 3));
            step();
        end
        rand_mode = 0; keep = '0;
        steps(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
